// File: rtl/ibex_ex_issue_ctrl_if.sv
// Issue / execute / writeback signal bundle for the EX issue controller.
// Latency: none, wires only.
// Backpressure: carries issue_ready_o and wb_ready_i handshakes between the decoder, EX blocks and writeback.
interface ibex_ex_issue_ctrl_if;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [1:0]        issue_class_i;
  logic [4:0]        issue_rd_i;
  logic              flush_i;

  logic              ex_mult_en_o;
  logic              ex_div_en_o;
  logic              ex_mult_sel_o;
  logic              ex_div_sel_o;
  logic              ex_fp_sel_o;
  logic              ex_alu_first_cycle_o;
  logic              ex_valid_i;
  logic [31:0]       ex_result_i;

  logic [1:0]        imd_val_we_i;
  logic [1:0][33:0]  imd_val_d_i;
  logic [1:0][33:0]  imd_val_q_o;

  logic              multdiv_ready_id_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [4:0]        wb_rd_o;
  logic [31:0]       wb_result_o;
  logic              busy_o;
  logic              timeout_o;

  // Environment side: decoder, execution blocks and writeback stage.
  modport master (
    output issue_valid_i, issue_class_i, issue_rd_i, flush_i,
    output ex_valid_i, ex_result_i, imd_val_we_i, imd_val_d_i, wb_ready_i,
    input  issue_ready_o, ex_mult_en_o, ex_div_en_o, ex_mult_sel_o, ex_div_sel_o,
    input  ex_fp_sel_o, ex_alu_first_cycle_o, imd_val_q_o, multdiv_ready_id_o,
    input  wb_valid_o, wb_rd_o, wb_result_o, busy_o, timeout_o
  );

  // Controller side.
  modport slave (
    input  issue_valid_i, issue_class_i, issue_rd_i, flush_i,
    input  ex_valid_i, ex_result_i, imd_val_we_i, imd_val_d_i, wb_ready_i,
    output issue_ready_o, ex_mult_en_o, ex_div_en_o, ex_mult_sel_o, ex_div_sel_o,
    output ex_fp_sel_o, ex_alu_first_cycle_o, imd_val_q_o, multdiv_ready_id_o,
    output wb_valid_o, wb_rd_o, wb_result_o, busy_o, timeout_o
  );
endinterface

// File: rtl/ibex_ex_issue_ctrl.sv
// Single-instruction issue controller: steers ALU/MUL/DIV/FP, captures the result, holds it for writeback.
// Latency: issue accepted -> EXEC next cycle; ex_valid_i in EXEC -> wb_valid_o next cycle.
// Backpressure: result held in HOLD until wb_ready_i; a new issue may be accepted in that same handshake cycle.
module ibex_ex_issue_ctrl #(
  parameter int unsigned MaxExecCycles = 40
) (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_ex_issue_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] ClsAlu = 2'b00;
  localparam logic [1:0] ClsMul = 2'b01;
  localparam logic [1:0] ClsDiv = 2'b10;
  localparam logic [1:0] ClsFp  = 2'b11;

  // Counter value seen in the last permitted EXEC cycle (first EXEC cycle sees 0).
  localparam logic [5:0] CntLast = 6'(MaxExecCycles - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cls_q;
  logic [4:0]       rd_q;
  logic [5:0]       cnt_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_result_q;
  logic [1:0][33:0] imd_q;

  logic in_idle, in_exec, in_hold;
  logic issue_ready, issue_fire, ex_done, wd_hit;

  assign in_idle = (state_q == IDLE);
  assign in_exec = (state_q == EXEC);
  assign in_hold = (state_q == HOLD);

  // Flush masks every event so nothing is accepted, captured or timed out in that cycle.
  assign issue_ready = ~bus.flush_i & (in_idle | (in_hold & bus.wb_ready_i));
  assign issue_fire  = bus.issue_valid_i & issue_ready;
  assign ex_done     = in_exec & bus.ex_valid_i & ~bus.flush_i;
  assign wd_hit      = in_exec & ~bus.ex_valid_i & ~bus.flush_i & (cnt_q == CntLast);

  // Next-state selection; flush beats everything, ex_valid_i beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (issue_fire) state_d = EXEC;
        EXEC: begin
          if (bus.ex_valid_i)  state_d = HOLD;
          else if (wd_hit)     state_d = IDLE;
        end
        HOLD: if (bus.wb_ready_i) state_d = issue_fire ? EXEC : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Latch class/rd of an accepted instruction and restart the EXEC cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cls_q <= ClsAlu;
      rd_q  <= 5'd0;
      cnt_q <= 6'd0;
    end else if (issue_fire) begin
      cls_q <= bus.issue_class_i;
      rd_q  <= bus.issue_rd_i;
      cnt_q <= 6'd0;
    end else if (in_exec && !bus.flush_i) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  // Capture the result for writeback; held untouched through HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_rd_q     <= 5'd0;
      wb_result_q <= 32'd0;
    end else if (ex_done) begin
      wb_rd_q     <= rd_q;
      wb_result_q <= bus.ex_result_i;
    end
  end

  // Intermediate value registers: written only during a live EXEC cycle, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_exec && !bus.flush_i && bus.imd_val_we_i[k]) imd_q[k] <= bus.imd_val_d_i[k];
      end
    end
  end

  assign bus.issue_ready_o        = issue_ready;
  assign bus.ex_mult_sel_o        = in_exec & (cls_q == ClsMul);
  assign bus.ex_div_sel_o         = in_exec & (cls_q == ClsDiv);
  assign bus.ex_fp_sel_o          = in_exec & (cls_q == ClsFp);
  assign bus.ex_mult_en_o         = in_exec & (cls_q == ClsMul) & ~bus.ex_valid_i;
  assign bus.ex_div_en_o          = in_exec & (cls_q == ClsDiv) & ~bus.ex_valid_i;
  assign bus.ex_alu_first_cycle_o = in_exec & (cnt_q == 6'd0);
  assign bus.multdiv_ready_id_o   = ex_done;
  assign bus.wb_valid_o           = in_hold;
  assign bus.wb_rd_o              = wb_rd_q;
  assign bus.wb_result_o          = wb_result_q;
  assign bus.imd_val_q_o          = imd_q;
  assign bus.busy_o               = ~in_idle;
  assign bus.timeout_o            = wd_hit;

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Directed bench for ibex_ex_issue_ctrl with a writeback scoreboard.
// Latency: drives at posedge+1, samples at posedge+2.
// Backpressure: exercises wb_ready_i stalls and back-to-back issue.
module tb_ibex_ex_issue_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [36:0] sb[$];

  ibex_ex_issue_ctrl_if bus();

  ibex_ex_issue_ctrl #(.MaxExecCycles(40)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Pop the oldest expected writeback and compare with the presented one.
  task automatic sb_check(input string tag);
    logic [36:0] e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb_empty observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rd"}, 64'(bus.wb_rd_o), 64'(e[36:32]));
      chk({tag, "_res"}, 64'(bus.wb_result_o), 64'(e[31:0]));
    end
  endtask

  task automatic issue(input logic [1:0] cls, input logic [4:0] rd);
    bus.issue_valid_i = 1'b1;
    bus.issue_class_i = cls;
    bus.issue_rd_i    = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    int wbv;
    logic [33:0] d0, d1;

    bus.issue_valid_i = 0; bus.issue_class_i = 0; bus.issue_rd_i = 0; bus.flush_i = 0;
    bus.ex_valid_i = 0; bus.ex_result_i = 0; bus.imd_val_we_i = 0; bus.imd_val_d_i = '0;
    bus.wb_ready_i = 0;

    // Reset values.
    #12;
    chk("rst_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_wbv", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_wbres", 64'(bus.wb_result_o), 64'd0);
    chk("rst_imd0", 64'(bus.imd_val_q_o[0]), 64'd0);
    chk("rst_to", 64'(bus.timeout_o), 64'd0);
    rst_ni = 1'b1;
    cyc();

    // ALU, result on first EXEC cycle.
    issue(2'b00, 5'd5);
    #1 chk("alu_ready", 64'(bus.issue_ready_o), 64'd1);
    cyc();
    bus.issue_valid_i = 0;
    bus.ex_valid_i = 1; bus.ex_result_i = 32'h0000_1234;
    sb.push_back({5'd5, 32'h0000_1234});
    #1 chk("alu_first", 64'(bus.ex_alu_first_cycle_o), 64'd1);
    chk("alu_mdrdy", 64'(bus.multdiv_ready_id_o), 64'd1);
    chk("alu_msel", 64'(bus.ex_mult_sel_o), 64'd0);
    cyc();
    bus.ex_valid_i = 0; bus.wb_ready_i = 1;
    #1 chk("alu_first_off", 64'(bus.ex_alu_first_cycle_o), 64'd0);
    chk("alu_wbv", 64'(bus.wb_valid_o), 64'd1);
    sb_check("alu_wb");
    cyc();
    bus.wb_ready_i = 0;
    #1 chk("alu_idle_wbv", 64'(bus.wb_valid_o), 64'd0);
    chk("alu_idle_busy", 64'(bus.busy_o), 64'd0);

    // DIV: 37 busy EXEC cycles with imd writes, result in the 38th.
    issue(2'b10, 5'd9);
    cyc();
    bus.issue_valid_i = 0;
    bus.imd_val_we_i = 2'b11;
    cnt = 0;
    for (int i = 0; i < 37; i++) begin
      bus.imd_val_d_i[0] = 34'(i);
      bus.imd_val_d_i[1] = 34'(1000 + i);
      #1;
      if (bus.ex_div_en_o === 1'b1) cnt++;
      if (bus.timeout_o !== 1'b0) cnt += 100;
      if (bus.multdiv_ready_id_o !== 1'b0) cnt += 1000;
      cyc();
    end
    chk("div_en_cycles", 64'(cnt), 64'd37);
    d0 = 34'h2_0000_0001; d1 = 34'h1_dead_beef;
    bus.imd_val_d_i[0] = d0; bus.imd_val_d_i[1] = d1;
    bus.ex_valid_i = 1; bus.ex_result_i = 32'hDEAD_0042;
    sb.push_back({5'd9, 32'hDEAD_0042});
    #1 chk("div_en_off", 64'(bus.ex_div_en_o), 64'd0);
    chk("div_sel", 64'(bus.ex_div_sel_o), 64'd1);
    chk("div_mdrdy", 64'(bus.multdiv_ready_id_o), 64'd1);
    cyc();
    bus.ex_valid_i = 0;
    bus.imd_val_d_i[0] = 34'h3_3333_3333; bus.imd_val_d_i[1] = 34'h0_5555_5555;
    #1 chk("div_mdrdy_off", 64'(bus.multdiv_ready_id_o), 64'd0);
    chk("div_imd0", 64'(bus.imd_val_q_o[0]), 64'(d0));
    chk("div_imd1", 64'(bus.imd_val_q_o[1]), 64'(d1));
    chk("div_divsel_hold", 64'(bus.ex_div_sel_o), 64'd0);
    cyc();
    #1 chk("div_imd0_hold", 64'(bus.imd_val_q_o[0]), 64'(d0));
    chk("div_imd1_hold", 64'(bus.imd_val_q_o[1]), 64'(d1));
    bus.imd_val_we_i = 2'b00;
    bus.wb_ready_i = 1;
    #1 sb_check("div_wb");
    cyc();
    bus.wb_ready_i = 0;

    // Watchdog on a MUL that never completes.
    issue(2'b01, 5'd3);
    cyc();
    bus.issue_valid_i = 0;
    cnt = 0; wbv = 0;
    for (int i = 0; i < 39; i++) begin
      #1;
      if (bus.timeout_o !== 1'b0) cnt += 100;
      if (bus.ex_mult_en_o === 1'b1) cnt++;
      if (bus.wb_valid_o !== 1'b0) wbv++;
      cyc();
    end
    chk("wd_pre_cycles", 64'(cnt), 64'd39);
    #1 chk("wd_pulse", 64'(bus.timeout_o), 64'd1);
    cyc();
    #1 chk("wd_pulse_off", 64'(bus.timeout_o), 64'd0);
    chk("wd_idle", 64'(bus.busy_o), 64'd0);
    if (bus.wb_valid_o !== 1'b0) wbv++;
    chk("wd_no_wb", 64'(wbv), 64'd0);

    // Backpressure then back-to-back issue.
    issue(2'b00, 5'd7);
    cyc();
    bus.issue_valid_i = 0;
    bus.ex_valid_i = 1; bus.ex_result_i = 32'h0000_A5A5;
    sb.push_back({5'd7, 32'h0000_A5A5});
    cyc();
    bus.ex_valid_i = 0;
    issue(2'b10, 5'd12);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_wbv", 64'(bus.wb_valid_o), 64'd1);
      chk("bp_rd", 64'(bus.wb_rd_o), 64'd7);
      chk("bp_res", 64'(bus.wb_result_o), 64'h0000_A5A5);
      chk("bp_ready", 64'(bus.issue_ready_o), 64'd0);
      cyc();
    end
    bus.wb_ready_i = 1;
    #1 chk("b2b_ready", 64'(bus.issue_ready_o), 64'd1);
    sb_check("bp_wb");
    cyc();
    bus.issue_valid_i = 0; bus.wb_ready_i = 0;
    #1 chk("b2b_busy", 64'(bus.busy_o), 64'd1);
    chk("b2b_divsel", 64'(bus.ex_div_sel_o), 64'd1);
    chk("b2b_first", 64'(bus.ex_alu_first_cycle_o), 64'd1);
    chk("b2b_wbv", 64'(bus.wb_valid_o), 64'd0);
    bus.ex_valid_i = 1; bus.ex_result_i = 32'h0000_0077;
    cyc();
    bus.ex_valid_i = 0;

    // Flush in HOLD with wb_ready_i and a pending issue: result is dropped.
    #1 chk("fl_wbv_pre", 64'(bus.wb_valid_o), 64'd1);
    chk("fl_rd_pre", 64'(bus.wb_rd_o), 64'd12);
    bus.flush_i = 1; bus.wb_ready_i = 1;
    issue(2'b01, 5'd20);
    #1 chk("fl_ready", 64'(bus.issue_ready_o), 64'd0);
    cyc();
    bus.flush_i = 0; bus.wb_ready_i = 0; bus.issue_valid_i = 0;
    #1 chk("fl_busy", 64'(bus.busy_o), 64'd0);
    chk("fl_wbv", 64'(bus.wb_valid_o), 64'd0);
    chk("fl_msel", 64'(bus.ex_mult_sel_o), 64'd0);

    // Reset in the middle of a DIV.
    issue(2'b10, 5'd1);
    cyc();
    bus.issue_valid_i = 0;
    bus.imd_val_we_i = 2'b01; bus.imd_val_d_i[0] = 34'h0_0000_0ABC;
    cyc();
    cyc();
    bus.imd_val_we_i = 2'b00;
    #1 chk("rm_div_en", 64'(bus.ex_div_en_o), 64'd1);
    rst_ni = 1'b0;
    #1 chk("rm_busy", 64'(bus.busy_o), 64'd0);
    chk("rm_div_en_rst", 64'(bus.ex_div_en_o), 64'd0);
    chk("rm_div_sel_rst", 64'(bus.ex_div_sel_o), 64'd0);
    chk("rm_imd0", 64'(bus.imd_val_q_o[0]), 64'd0);
    chk("rm_wbres", 64'(bus.wb_result_o), 64'd0);
    chk("rm_wbrd", 64'(bus.wb_rd_o), 64'd0);
    chk("rm_ready", 64'(bus.issue_ready_o), 64'd1);
    #2 rst_ni = 1'b1;
    cyc();
    wbv = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0) wbv++;
      cyc();
    end
    chk("rm_no_wb", 64'(wbv), 64'd0);
    chk("rm_ready_after", 64'(bus.issue_ready_o), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
